// File: rtl/mips_pkg.sv
// Shared loader types and constants.
// IMEM_LOADER_CHECKSUM_EN adds the CHK state for the trailing XOR byte.
package mips_pkg;

  localparam int MAX_WORDS_DEF = 64;
  localparam int HDR_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } ld_state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Big-endian 4-byte word assembler.
// Emits a one-cycle word_valid after the 4th byte.
module imem_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  count,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh         <= '0;
      count      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        sh    <= '0;
        count <= '0;
      end else if (byte_valid) begin
        sh    <= {sh[15:0], byte_data};
        count <= count + 2'd1;
        if (count == 2'd3) begin
          word_valid <= 1'b1;
          word       <= {sh, byte_data};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Serial-link instruction memory loader: header, payload, optional XOR byte.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum byte.
module imem_loader
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam ld_state_t PAY_END = CHK;
`else
  localparam ld_state_t PAY_END = DONE;
`endif

  ld_state_t        state, nxt;
  logic [7:0]       hdr_hi;
  logic [HDR_W-1:0] n, wcnt, hdr_n;
  logic [31:0]      addr;
  logic [1:0]       count;
  logic             word_valid;
  logic [31:0]      word;
  logic             xfer, start_ok, pack_in, last_byte;

  assign xfer     = rx_valid && rx_ready;
  assign hdr_n    = {hdr_hi, rx_data};
  assign start_ok = start &&
    (state == IDLE || state == DONE || state == ERR);
  assign pack_in  = xfer && (state == DATA);
  // Leave DATA on the last byte so a following byte is never absorbed.
  assign last_byte = pack_in && (count == 2'd3) &&
    (wcnt == n - 16'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum <= '0;
    else if (start_ok) csum <= '0;
    else if (xfer && state != CHK) csum <= csum ^ rx_data;
  end
`endif

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_ok),
    .byte_valid (pack_in),
    .byte_data  (rx_data),
    .count      (count),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      hdr_hi <= '0;
      n      <= '0;
      wcnt   <= '0;
      addr   <= BASE_ADDR;
    end else begin
      state <= nxt;
      if (start_ok) begin
        n    <= '0;
        wcnt <= '0;
        addr <= BASE_ADDR;
      end else begin
        if (xfer && state == HDR_HI) hdr_hi <= rx_data;
        if (xfer && state == HDR_LO) n <= hdr_n;
        if (pack_in && count == 2'd3) wcnt <= wcnt + 16'd1;
        if (word_valid) addr <= addr + 32'd4;
      end
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE, ERR: if (start) nxt = HDR_HI;
      HDR_HI: if (xfer) nxt = HDR_LO;
      HDR_LO: if (xfer) begin
        if (hdr_n > HDR_W'(MAX_WORDS)) nxt = ERR;
        else if (hdr_n == '0) nxt = PAY_END;
        else nxt = DATA;
      end
      DATA: if (last_byte) nxt = PAY_END;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: if (xfer) nxt = (rx_data == csum) ? DONE : ERR;
`endif
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    cpu_hold = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state)
      HDR_HI, HDR_LO, DATA: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
      end
`endif
      DONE: done = 1'b1;
      ERR: begin
        error    = 1'b1;
        cpu_hold = 1'b1;
      end
      default: ;
    endcase
  end

  assign imem_we    = word_valid;
  assign imem_addr  = addr;
  assign imem_wdata = word;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first instruction word written.
REQ-002 Parameter MAX_WORDS, default 64: largest word count accepted in a header.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port start, input, 1: one-cycle request to begin a load session.
REQ-006 Port rx_valid, input, 1: rx_data holds a valid byte.
REQ-007 Port rx_data, input, 8: serial-link byte.
REQ-008 Port rx_ready, output, 1: loader accepts a byte this cycle; a byte transfers when rx_valid && rx_ready.
REQ-009 Port imem_we, output, 1: instruction-memory write strobe.
REQ-010 Port imem_addr, output, 32: write byte address, word-aligned.
REQ-011 Port imem_wdata, output, 32: instruction word to write.
REQ-012 Port cpu_hold, output, 1: holds the processor PC/fetch while loading.
REQ-013 Port done, output, 1: session completed successfully.
REQ-014 Port error, output, 1: session aborted.

Function
REQ-015 States: IDLE, HDR_HI, HDR_LO, DATA, CHK, DONE, ERR.
REQ-016 IDLE, DONE, ERR: start=1 -> HDR_HI; clears done, error, word counter, byte counter and checksum.
REQ-017 start is ignored in HDR_HI, HDR_LO, DATA and CHK.
REQ-018 rx_ready = 1 exactly in HDR_HI, HDR_LO, DATA, CHK; rx_ready = 0 elsewhere.
REQ-019 Header: 16-bit word count N, big-endian, high byte first; HDR_HI -> HDR_LO -> DATA on successive transfers.
REQ-020 N > MAX_WORDS -> ERR after the low header byte; no memory writes occur.
REQ-021 N == 0 -> DONE, or CHK when checksum is enabled.
REQ-022 DATA: 4 bytes per word, big-endian, first byte into bits [31:24].
REQ-023 On the cycle after the 4th byte transfer: imem_we = 1 for exactly one cycle, imem_wdata = assembled word, imem_addr = BASE_ADDR + 4*k, where k is the 0-based word index.
REQ-024 Gaps on rx_valid stall assembly without loss; back-to-back bytes produce one write every 4 cycles minimum.
REQ-025 After word N-1 is written -> DONE, or CHK when checksum is enabled.
REQ-026 done = 1 in DONE; error = 1 in ERR; both are sticky until the next start or reset.
REQ-027 cpu_hold = 1 from the cycle after start through HDR/DATA/CHK; it remains 1 in ERR and is 0 in IDLE and DONE.
REQ-028 imem_we is never asserted outside DATA-driven writes; imem_addr does not wrap (bounded by MAX_WORDS).

Reset
REQ-029 rst_n low asynchronously forces IDLE and drives rx_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=0, done=0, error=0, with all counters and the checksum at 0.
REQ-030 Reset mid-session abandons the session; a partially assembled word is never written.

Configuration
REQ-031 Macro IMEM_LOADER_CHECKSUM_EN defined: after the payload, one trailing byte in state CHK equals the XOR of all header and payload bytes; match -> DONE, mismatch -> ERR. Words already written stay written.
REQ-032 Macro absent: no CHK state, no trailing byte, and the checksum logic is omitted.

Structure
REQ-033 Shared package mips_pkg holds the loader state enum, the default MAX_WORDS constant and the header width constant (16).
REQ-034 Sub-module imem_byte_packer: a 4-byte big-endian shift register with a byte counter and a word_valid pulse; the FSM, address counter and checksum live in imem_loader.

Verification
REQ-035 Header 00 02, bytes 20 08 00 05 / AC 08 00 00, no gaps -> two imem_we pulses: addr 0x0 data 0x20080005, then addr 0x4 data 0xAC080000; then done=1, cpu_hold=0.
REQ-036 Same stream with rx_valid toggling every other cycle -> identical writes and final state; no byte lost.
REQ-037 Header 00 41 (65 > 64) -> error=1, zero imem_we pulses, rx_ready=0, cpu_hold=1.
REQ-038 Header 00 00 -> done=1 with no writes; with IMEM_LOADER_CHECKSUM_EN, trailing byte 00 -> done, trailing byte 01 -> error.
REQ-039 rst_n asserted after 6 payload bytes of a 2-word load -> exactly 1 write seen; all outputs at reset values; a fresh start then loads correctly.
REQ-040 With IMEM_LOADER_CHECKSUM_EN, the REQ-035 stream plus trailing byte 0x8B -> done; trailing byte 0x8C -> error after both writes.
